kamacore_writeback_stage: RTL

Memory/writeback stage between execute and the register file write port. Accepts one retired operation per handshake from execute. ALU results pass straight to the write port. Loads and stores are sequenced over a simple data-memory request/response interface, and load data is lane-aligned and sign/zero-extended before writeback.

---
 rtl/kamacore_writeback_stage.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/kamacore_writeback_stage.sv
// ---------------------------------------------------------------------------
// kamacore_writeback_stage
//
// Memory/writeback stage sitting between execute and the register file write
// port. One retired operation is accepted per ex_valid/ex_ready handshake.
// ALU results go straight to the (registered) write port. Loads and stores
// are sequenced over a simple request/response data-memory interface; load
// data is lane-aligned and sign/zero-extended before writeback.
//
// Ports:
//   i_clk, i_rst_n            clock (rising edge), async active-low reset
//   i_ex_*, o_ex_ready        operation handshake from execute
//   o_mem_req_*, i_mem_req_ready
//                             data-memory request (held stable until ready)
//   i_mem_rsp_valid/data      load response, only honoured while waiting
//   o_destination_we/a/data   registered register-file write port
//   o_misaligned_err          one-cycle pulse for a rejected access
// ---------------------------------------------------------------------------
module kamacore_writeback_stage #(
  parameter int CPU_WIDTH      = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_ex_valid,
  output logic                      o_ex_ready,
  input  logic [CPU_WIDTH-1:0]      i_ex_result,
  input  logic [REG_ADDR_WIDTH-1:0] i_ex_rd_a,
  input  logic                      i_ex_rd_we,
  input  logic                      i_ex_is_load,
  input  logic                      i_ex_is_store,
  input  logic [1:0]                i_ex_mem_size,
  input  logic                      i_ex_mem_unsigned,
  input  logic [CPU_WIDTH-1:0]      i_ex_store_data,
  output logic                      o_mem_req_valid,
  input  logic                      i_mem_req_ready,
  output logic                      o_mem_req_we,
  output logic [CPU_WIDTH-1:0]      o_mem_req_addr,
  output logic [CPU_WIDTH-1:0]      o_mem_req_wdata,
  output logic [3:0]                o_mem_req_be,
  input  logic                      i_mem_rsp_valid,
  input  logic [CPU_WIDTH-1:0]      i_mem_rsp_data,
  output logic                      o_destination_we,
  output logic [REG_ADDR_WIDTH-1:0] o_destination_a,
  output logic [CPU_WIDTH-1:0]      o_destination_data,
  output logic                      o_misaligned_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;

  // Latched memory-operation context
  logic [CPU_WIDTH-1:0]      r_req_addr;
  logic [CPU_WIDTH-1:0]      r_req_wdata;
  logic [3:0]                r_req_be;
  logic                      r_req_we;
  logic [1:0]                r_addr_lo;
  logic [1:0]                r_size;
  logic                      r_unsigned;
  logic [REG_ADDR_WIDTH-1:0] r_rd;
  logic                      r_rd_we;

  // Registered outputs
  logic                      r_dest_we;
  logic [REG_ADDR_WIDTH-1:0] r_dest_a;
  logic [CPU_WIDTH-1:0]      r_dest_data;
  logic                      r_err;

  logic                      w_accept;
  logic                      w_is_mem;
  logic                      w_misaligned;
  logic [3:0]                w_store_be;
  logic [CPU_WIDTH-1:0]      w_store_wdata;
  logic [CPU_WIDTH-1:0]      w_shifted;
  logic [CPU_WIDTH-1:0]      w_load_data;

  // ex_ready is gated by reset so the stage never advertises acceptance
  // while reset is asserted, even though the state register reads IDLE.
  assign o_ex_ready   = (r_state == ST_IDLE) && i_rst_n;
  assign w_accept     = i_ex_valid && o_ex_ready;
  assign w_is_mem     = i_ex_is_load || i_ex_is_store;
  assign w_misaligned = (i_ex_mem_size == 2'd3) ||
                        ((i_ex_mem_size == 2'd1) && i_ex_result[0]) ||
                        ((i_ex_mem_size == 2'd2) && (i_ex_result[1:0] != 2'b00));

  // Store lane enables and lane replication, so memory can pick the byte
  // lanes selected by the enables without any further shifting.
  always_comb begin
    w_store_be    = 4'b1111;
    w_store_wdata = i_ex_store_data;
    case (i_ex_mem_size)
      2'd0: begin
        w_store_be    = 4'b0001 << i_ex_result[1:0];
        w_store_wdata = {4{i_ex_store_data[7:0]}};
      end
      2'd1: begin
        w_store_be    = 4'b0011 << i_ex_result[1:0];
        w_store_wdata = {2{i_ex_store_data[15:0]}};
      end
      default: begin
        w_store_be    = 4'b1111;
        w_store_wdata = i_ex_store_data;
      end
    endcase
  end

  // Bring the addressed lane down to bit 0, then extend to full width.
  assign w_shifted = i_mem_rsp_data >> {r_addr_lo, 3'b000};

  always_comb begin
    w_load_data = w_shifted;
    case (r_size)
      2'd0: w_load_data = r_unsigned ? {{(CPU_WIDTH-8){1'b0}}, w_shifted[7:0]}
                                     : {{(CPU_WIDTH-8){w_shifted[7]}}, w_shifted[7:0]};
      2'd1: w_load_data = r_unsigned ? {{(CPU_WIDTH-16){1'b0}}, w_shifted[15:0]}
                                     : {{(CPU_WIDTH-16){w_shifted[15]}}, w_shifted[15:0]};
      default: w_load_data = w_shifted;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Stores are posted, so they return to IDLE straight from REQ.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && w_is_mem && !w_misaligned) begin
          w_next_state = ST_REQ;
        end
      end
      ST_REQ: begin
        if (i_mem_req_ready) begin
          w_next_state = r_req_we ? ST_IDLE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (i_mem_rsp_valid) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Datapath: capture operation context at accept and produce the
  // registered write/error pulses. destination_a/data only change when a
  // write actually happens, so they hold their last value otherwise.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_req_addr  <= '0;
      r_req_wdata <= '0;
      r_req_be    <= '0;
      r_req_we    <= 1'b0;
      r_addr_lo   <= '0;
      r_size      <= '0;
      r_unsigned  <= 1'b0;
      r_rd        <= '0;
      r_rd_we     <= 1'b0;
      r_dest_we   <= 1'b0;
      r_dest_a    <= '0;
      r_dest_data <= '0;
      r_err       <= 1'b0;
    end else begin
      r_dest_we <= 1'b0;
      r_err     <= 1'b0;
      if ((r_state == ST_IDLE) && w_accept) begin
        if (!w_is_mem) begin
          if (i_ex_rd_we && (i_ex_rd_a != '0)) begin
            r_dest_we   <= 1'b1;
            r_dest_a    <= i_ex_rd_a;
            r_dest_data <= i_ex_result;
          end
        end else if (w_misaligned) begin
          r_err <= 1'b1;
        end else begin
          r_req_addr  <= {i_ex_result[CPU_WIDTH-1:2], 2'b00};
          r_addr_lo   <= i_ex_result[1:0];
          r_req_we    <= !i_ex_is_load;
          r_req_be    <= i_ex_is_load ? 4'b0000 : w_store_be;
          r_req_wdata <= i_ex_is_load ? '0 : w_store_wdata;
          r_size      <= i_ex_mem_size;
          r_unsigned  <= i_ex_mem_unsigned;
          r_rd        <= i_ex_rd_a;
          r_rd_we     <= i_ex_rd_we;
        end
      end
      if ((r_state == ST_WAIT) && i_mem_rsp_valid && r_rd_we && (r_rd != '0)) begin
        r_dest_we   <= 1'b1;
        r_dest_a    <= r_rd;
        r_dest_data <= w_load_data;
      end
    end
  end

  assign o_mem_req_valid    = (r_state == ST_REQ);
  assign o_mem_req_we       = r_req_we;
  assign o_mem_req_addr     = r_req_addr;
  assign o_mem_req_wdata    = r_req_wdata;
  assign o_mem_req_be       = r_req_be;
  assign o_destination_we   = r_dest_we;
  assign o_destination_a    = r_dest_a;
  assign o_destination_data = r_dest_data;
  assign o_misaligned_err   = r_err;

endmodule
